// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bundle: decode redirects, hazard/SRAM holds and the fetch-side outputs.
// The master side is the pipeline (hazard unit, decode, SRAM); the slave side is pc_fetch_ctrl.
interface pc_fetch_ctrl_if #(
    parameter int PERF_W = 32
);
    logic              stallF;
    logic              stallD;
    logic              inst_busy;
    logic              jumpD;
    logic [31:0]       pc_jumpD;
    logic              branchD;
    logic [31:0]       pc_branchD;
    logic              flush_exc;
    logic [31:0]       pc_exc;
    logic [31:0]       pcF;
    logic              inst_req;
    logic              is_in_delayslotF;
    logic              adelF;
    logic [PERF_W-1:0] perf_redirect_cnt;
    logic [PERF_W-1:0] perf_pend_cnt;
    logic [1:0]        state_dbg;

    modport master (
        output stallF, stallD, inst_busy, jumpD, pc_jumpD, branchD, pc_branchD,
               flush_exc, pc_exc,
        input  pcF, inst_req, is_in_delayslotF, adelF, perf_redirect_cnt,
               perf_pend_cnt, state_dbg
    );

    modport slave (
        input  stallF, stallD, inst_busy, jumpD, pc_jumpD, branchD, pc_branchD,
               flush_exc, pc_exc,
        output pcF, inst_req, is_in_delayslotF, adelF, perf_redirect_cnt,
               perf_pend_cnt, state_dbg
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC owner with MIPS delay-slot handling and buffered branch/exception redirects.
// Optional performance counters are built only when PC_FETCH_PERF_EN is defined.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          PERF_W   = 32
) (
    input  logic           clk,
    input  logic           rst,
    pc_fetch_ctrl_if.slave bus
);
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_BR_PEND  = 2'd1;
    localparam logic [1:0] ST_EXC_PEND = 2'd2;

    logic [1:0]  state_q, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] pend_q, pend_n;
    logic        rst_q;
    logic        adv;
    logic        cap;
    logic [31:0] tgt;

    // Request/hold handshake: a fetch of pcF is presented whenever inst_req=1; the SRAM holds
    // inst_busy=1 until it has accepted it, and pcF only moves on a cycle with inst_busy=0.
    assign adv = ~bus.stallF & ~bus.inst_busy;
    assign cap = (bus.jumpD | bus.branchD) & ~bus.stallD;
    assign tgt = bus.jumpD ? bus.pc_jumpD : bus.pc_branchD;

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        pend_n  = pend_q;
        case (state_q)
            ST_RUN: begin
                if (bus.flush_exc) begin
                    if (!bus.inst_busy) begin
                        pc_n = bus.pc_exc;
                    end else begin
                        pend_n  = bus.pc_exc;
                        state_n = ST_EXC_PEND;
                    end
                end else if (cap) begin
                    // Delay slot retires this cycle when adv, so the target goes straight in.
                    if (adv) begin
                        pc_n = tgt;
                    end else begin
                        pend_n  = tgt;
                        state_n = ST_BR_PEND;
                    end
                end else if (adv) begin
                    pc_n = pc_q + 32'd4;
                end
            end
            ST_BR_PEND: begin
                if (bus.flush_exc) begin
                    if (!bus.inst_busy) begin
                        pc_n    = bus.pc_exc;
                        state_n = ST_RUN;
                    end else begin
                        pend_n  = bus.pc_exc;
                        state_n = ST_EXC_PEND;
                    end
                end else if (adv) begin
                    pc_n    = pend_q;
                    state_n = ST_RUN;
                end
            end
            ST_EXC_PEND: begin
                // Only the SRAM matters here: the in-flight fetch must drain before redirecting.
                if (bus.flush_exc) begin
                    if (!bus.inst_busy) begin
                        pc_n    = bus.pc_exc;
                        state_n = ST_RUN;
                    end else begin
                        pend_n = bus.pc_exc;
                    end
                end else if (!bus.inst_busy) begin
                    pc_n    = pend_q;
                    state_n = ST_RUN;
                end
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            pend_q  <= 32'd0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            pend_q  <= pend_n;
        end
    end

    assign bus.pcF              = pc_q;
    assign bus.adelF            = |pc_q[1:0];
    assign bus.inst_req         = ~rst_q & ~(|pc_q[1:0]) & (state_q != ST_EXC_PEND);
    assign bus.is_in_delayslotF = ~bus.flush_exc &
                                  (((state_q == ST_RUN) & cap) | (state_q == ST_BR_PEND));
    assign bus.state_dbg        = state_q;

`ifdef PC_FETCH_PERF_EN
    logic [PERF_W-1:0] redirect_cnt_q;
    logic [PERF_W-1:0] pend_cnt_q;
    logic              redirect_load;

    // Loads of pcF from a decode target or from pend_pc; direct pc_exc loads are not counted.
    assign redirect_load = ~bus.flush_exc &
                           (((state_q == ST_RUN) & cap & adv) |
                            ((state_q == ST_BR_PEND) & adv) |
                            ((state_q == ST_EXC_PEND) & ~bus.inst_busy));

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt_q <= '0;
            pend_cnt_q     <= '0;
        end else begin
            if (redirect_load) begin
                redirect_cnt_q <= redirect_cnt_q + 1'b1;
            end
            if (state_q == ST_BR_PEND) begin
                pend_cnt_q <= pend_cnt_q + 1'b1;
            end
        end
    end

    assign bus.perf_redirect_cnt = redirect_cnt_q;
    assign bus.perf_pend_cnt     = pend_cnt_q;
`else
    assign bus.perf_redirect_cnt = {PERF_W{1'b0}};
    assign bus.perf_pend_cnt     = {PERF_W{1'b0}};
`endif

    // Decode must never present a jump and a taken branch together.
    a_no_dual_redirect: assert property (@(posedge clk) disable iff (rst)
        !(bus.jumpD && bus.branchD));

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: reset, free run, redirects, pending states and stalls.
module tb_pc_fetch_ctrl;
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_BR_PEND  = 2'd1;
    localparam logic [1:0] ST_EXC_PEND = 2'd2;
`ifdef PC_FETCH_PERF_EN
    localparam logic [31:0] EXP_PEND_CNT = 32'd3;
`else
    localparam logic [31:0] EXP_PEND_CNT = 32'd0;
`endif

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [31:0] exp_q[$];

    pc_fetch_ctrl_if #(.PERF_W(32)) bus ();

    pc_fetch_ctrl #(.RESET_PC(32'hBFC0_0000), .PERF_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stallF     = 1'b0;
        bus.stallD     = 1'b0;
        bus.inst_busy  = 1'b0;
        bus.jumpD      = 1'b0;
        bus.pc_jumpD   = 32'd0;
        bus.branchD    = 1'b0;
        bus.pc_branchD = 32'd0;
        bus.flush_exc  = 1'b0;
        bus.pc_exc     = 32'd0;
    endtask

    task automatic do_reset(input int n_adv);
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (n_adv) tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++; if (bus.pcF !== 32'hBFC00000) $display("FAIL reset_pcF: got %h want %h", bus.pcF, 32'hBFC00000); else n_pass++;
        n_checks++; if (bus.inst_req !== 1'b0) $display("FAIL reset_inst_req: got %b want 0", bus.inst_req); else n_pass++;
        n_checks++; if (bus.is_in_delayslotF !== 1'b0) $display("FAIL reset_ds: got %b want 0", bus.is_in_delayslotF); else n_pass++;
        n_checks++; if (bus.adelF !== 1'b0) $display("FAIL reset_adelF: got %b want 0", bus.adelF); else n_pass++;
        n_checks++; if (bus.state_dbg !== ST_RUN) $display("FAIL reset_state: got %0d want %0d", bus.state_dbg, ST_RUN); else n_pass++;
        n_checks++; if (bus.perf_pend_cnt !== 32'd0 || bus.perf_redirect_cnt !== 32'd0)
            $display("FAIL reset_perf: got %0d/%0d want 0/0", bus.perf_pend_cnt, bus.perf_redirect_cnt); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        logic [31:0] exp;
        exp_q.push_back(32'hBFC00000);
        exp_q.push_back(32'hBFC00004);
        exp_q.push_back(32'hBFC00008);
        for (int i = 0; i < 3; i++) begin
            exp = exp_q.pop_front();
            n_checks++; if (bus.pcF !== exp) $display("FAIL free_run_pcF[%0d]: got %h want %h", i, bus.pcF, exp); else n_pass++;
            if (i > 0) begin
                n_checks++; if (bus.inst_req !== 1'b1) $display("FAIL free_run_inst_req[%0d]: got %b want 1", i, bus.inst_req); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_jump_adv();
        do_reset(4);
        bus.jumpD    = 1'b1;
        bus.pc_jumpD = 32'h80001000;
        #1;
        n_checks++; if (bus.is_in_delayslotF !== 1'b1) $display("FAIL jump_adv_ds: got %b want 1", bus.is_in_delayslotF); else n_pass++;
        tick();
        bus.jumpD = 1'b0;
        #1;
        n_checks++; if (bus.pcF !== 32'h80001000) $display("FAIL jump_adv_pcF: got %h want %h", bus.pcF, 32'h80001000); else n_pass++;
        n_checks++; if (bus.is_in_delayslotF !== 1'b0) $display("FAIL jump_adv_ds_after: got %b want 0", bus.is_in_delayslotF); else n_pass++;
    endtask

    task automatic test_jump_busy();
        do_reset(4);
        bus.jumpD     = 1'b1;
        bus.pc_jumpD  = 32'h80001000;
        bus.inst_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (bus.pcF !== 32'hBFC00010) $display("FAIL jump_busy_hold[%0d]: got %h want %h", i, bus.pcF, 32'hBFC00010); else n_pass++;
            n_checks++; if (bus.is_in_delayslotF !== 1'b1) $display("FAIL jump_busy_ds[%0d]: got %b want 1", i, bus.is_in_delayslotF); else n_pass++;
            tick();
            bus.jumpD = 1'b0;
        end
        bus.inst_busy = 1'b0;
        #1;
        n_checks++; if (bus.state_dbg !== ST_BR_PEND) $display("FAIL jump_busy_state: got %0d want %0d", bus.state_dbg, ST_BR_PEND); else n_pass++;
        tick();
        n_checks++; if (bus.pcF !== 32'h80001000) $display("FAIL jump_busy_target: got %h want %h", bus.pcF, 32'h80001000); else n_pass++;
        n_checks++; if (bus.state_dbg !== ST_RUN) $display("FAIL jump_busy_run: got %0d want %0d", bus.state_dbg, ST_RUN); else n_pass++;
        n_checks++; if (bus.perf_pend_cnt !== EXP_PEND_CNT) $display("FAIL jump_busy_perf: got %0d want %0d", bus.perf_pend_cnt, EXP_PEND_CNT); else n_pass++;
    endtask

    task automatic test_exc_in_pend();
        do_reset(4);
        bus.jumpD     = 1'b1;
        bus.pc_jumpD  = 32'h80001000;
        bus.inst_busy = 1'b1;
        tick();
        bus.jumpD     = 1'b0;
        bus.flush_exc = 1'b1;
        bus.pc_exc    = 32'hBFC00380;
        #1;
        n_checks++; if (bus.is_in_delayslotF !== 1'b0) $display("FAIL exc_flush_ds: got %b want 0", bus.is_in_delayslotF); else n_pass++;
        tick();
        bus.flush_exc = 1'b0;
        bus.stallF    = 1'b1;
        #1;
        n_checks++; if (bus.state_dbg !== ST_EXC_PEND) $display("FAIL exc_state: got %0d want %0d", bus.state_dbg, ST_EXC_PEND); else n_pass++;
        n_checks++; if (bus.inst_req !== 1'b0) $display("FAIL exc_inst_req: got %b want 0", bus.inst_req); else n_pass++;
        n_checks++; if (bus.is_in_delayslotF !== 1'b0) $display("FAIL exc_ds: got %b want 0", bus.is_in_delayslotF); else n_pass++;
        tick();
        bus.inst_busy = 1'b0;
        tick();
        n_checks++; if (bus.pcF !== 32'hBFC00380) $display("FAIL exc_target: got %h want %h", bus.pcF, 32'hBFC00380); else n_pass++;
        n_checks++; if (bus.inst_req !== 1'b1) $display("FAIL exc_req_after: got %b want 1", bus.inst_req); else n_pass++;
        bus.stallF = 1'b0;
        tick();
        n_checks++; if (bus.pcF !== 32'hBFC00384) $display("FAIL exc_no_branch: got %h want %h", bus.pcF, 32'hBFC00384); else n_pass++;
    endtask

    task automatic test_misaligned();
        do_reset(1);
        bus.branchD    = 1'b1;
        bus.pc_branchD = 32'h80000002;
        tick();
        bus.branchD = 1'b0;
        #1;
        n_checks++; if (bus.pcF !== 32'h80000002) $display("FAIL adel_pcF: got %h want %h", bus.pcF, 32'h80000002); else n_pass++;
        n_checks++; if (bus.adelF !== 1'b1) $display("FAIL adel_flag: got %b want 1", bus.adelF); else n_pass++;
        n_checks++; if (bus.inst_req !== 1'b0) $display("FAIL adel_inst_req: got %b want 0", bus.inst_req); else n_pass++;
        bus.flush_exc = 1'b1;
        bus.pc_exc    = 32'hBFC00380;
        tick();
        bus.flush_exc = 1'b0;
        #1;
        n_checks++; if (bus.pcF !== 32'hBFC00380) $display("FAIL adel_exc_pcF: got %h want %h", bus.pcF, 32'hBFC00380); else n_pass++;
        n_checks++; if (bus.adelF !== 1'b0) $display("FAIL adel_cleared: got %b want 0", bus.adelF); else n_pass++;
        n_checks++; if (bus.inst_req !== 1'b1) $display("FAIL adel_req_back: got %b want 1", bus.inst_req); else n_pass++;
    endtask

    task automatic test_cap_and_flush();
        do_reset(2);
        bus.jumpD     = 1'b1;
        bus.pc_jumpD  = 32'h80001000;
        bus.flush_exc = 1'b1;
        bus.pc_exc    = 32'hBFC00380;
        #1;
        n_checks++; if (bus.is_in_delayslotF !== 1'b0) $display("FAIL capflush_ds: got %b want 0", bus.is_in_delayslotF); else n_pass++;
        tick();
        bus.jumpD     = 1'b0;
        bus.flush_exc = 1'b0;
        #1;
        n_checks++; if (bus.pcF !== 32'hBFC00380) $display("FAIL capflush_pcF: got %h want %h", bus.pcF, 32'hBFC00380); else n_pass++;
        n_checks++; if (bus.state_dbg !== ST_RUN) $display("FAIL capflush_state: got %0d want %0d", bus.state_dbg, ST_RUN); else n_pass++;
    endtask

    task automatic test_reset_in_pend();
        bus.jumpD     = 1'b1;
        bus.pc_jumpD  = 32'h80001000;
        bus.inst_busy = 1'b1;
        tick();
        bus.jumpD = 1'b0;
        #1;
        n_checks++; if (bus.state_dbg !== ST_BR_PEND) $display("FAIL rstpend_pend: got %0d want %0d", bus.state_dbg, ST_BR_PEND); else n_pass++;
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        bus.inst_busy = 1'b0;
        #1;
        n_checks++; if (bus.pcF !== 32'hBFC00000) $display("FAIL rstpend_pcF: got %h want %h", bus.pcF, 32'hBFC00000); else n_pass++;
        n_checks++; if (bus.state_dbg !== ST_RUN) $display("FAIL rstpend_state: got %0d want %0d", bus.state_dbg, ST_RUN); else n_pass++;
        tick();
        n_checks++; if (bus.pcF !== 32'hBFC00004) $display("FAIL rstpend_lost: got %h want %h", bus.pcF, 32'hBFC00004); else n_pass++;
    endtask

    task automatic test_stalls_and_wrap();
        do_reset(1);
        bus.stallF = 1'b1;
        tick();
        n_checks++; if (bus.pcF !== 32'hBFC00004) $display("FAIL stallF_hold: got %h want %h", bus.pcF, 32'hBFC00004); else n_pass++;
        bus.stallF   = 1'b0;
        bus.stallD   = 1'b1;
        bus.jumpD    = 1'b1;
        bus.pc_jumpD = 32'h80001000;
        #1;
        n_checks++; if (bus.is_in_delayslotF !== 1'b0) $display("FAIL stallD_ds: got %b want 0", bus.is_in_delayslotF); else n_pass++;
        tick();
        bus.stallD   = 1'b0;
        bus.pc_jumpD = 32'hFFFFFFFC;
        #1;
        n_checks++; if (bus.pcF !== 32'hBFC00008) $display("FAIL stallD_nocap: got %h want %h", bus.pcF, 32'hBFC00008); else n_pass++;
        tick();
        bus.jumpD = 1'b0;
        #1;
        n_checks++; if (bus.pcF !== 32'hFFFFFFFC) $display("FAIL wrap_pre: got %h want %h", bus.pcF, 32'hFFFFFFFC); else n_pass++;
        tick();
        n_checks++; if (bus.pcF !== 32'h00000000) $display("FAIL wrap_pcF: got %h want %h", bus.pcF, 32'h00000000); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset(1);
        bus.branchD    = 1'b1;
        bus.pc_branchD = 32'h80001000;
        tick();
        bus.branchD  = 1'b0;
        bus.jumpD    = 1'b1;
        bus.pc_jumpD = 32'h80002000;
        #1;
        n_checks++; if (bus.pcF !== 32'h80001000) $display("FAIL b2b_first: got %h want %h", bus.pcF, 32'h80001000); else n_pass++;
        tick();
        bus.jumpD = 1'b0;
        #1;
        n_checks++; if (bus.pcF !== 32'h80002000) $display("FAIL b2b_second: got %h want %h", bus.pcF, 32'h80002000); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_free_run();
        test_jump_adv();
        test_jump_busy();
        test_exc_in_pend();
        test_misaligned();
        test_cap_and_flush();
        test_reset_in_pend();
        test_stalls_and_wrap();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
